braille_playback_sequencer: RTL and testbench

//  Generates the `next` advance pulse and a pipeline restart for the braille converter/memory/reader chain.

---
 rtl/braille_pkg.sv | 22 ++
 rtl/braille_playback_sequencer_button_debounce.sv | 47 ++++
 rtl/braille_playback_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_braille_playback_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/braille_pkg.sv
// Shared types and constants for the braille playback sequencer and its button front end.
package braille_pkg;

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    PLAY    = 2'd1,
    RESTART = 2'd2
  } seq_state_t;

  localparam logic [1:0] DWELL_SEL_1X = 2'd0;
  localparam logic [1:0] DWELL_SEL_2X = 2'd1;
  localparam logic [1:0] DWELL_SEL_4X = 2'd2;
  localparam logic [1:0] DWELL_SEL_8X = 2'd3;

  localparam logic [7:0] CELL_COUNT_MAX = 8'd255;

  // Dwell period in cycles for a given base and multiplier select.
  function automatic int unsigned dwell_period(input int unsigned base, input logic [1:0] sel);
    return base << sel;
  endfunction

endpackage

// File: rtl/braille_playback_sequencer_button_debounce.sv
// One push-button front end: 2-FF synchroniser, stability debounce, and a one-cycle
// press event on each accepted rising level. Raw edge to press is 2+DEBOUNCE_CYCLES+1 cycles.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments so every flop samples its pre-edge inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      // Any return to the accepted level restarts the stability window.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/braille_playback_sequencer.sv
// Playback sequencer: turns debounced buttons into gated `next` advances (manual or timed)
// and a fixed-length pipeline restart for the braille converter/memory/reader chain.
module braille_playback_sequencer
  import braille_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DWELL_BASE      = 1024,
  parameter int RESTART_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next_raw,
  input  logic       btn_play_raw,
  input  logic       btn_rst_raw,
  input  logic [1:0] dwell_sel,
  input  logic       braille_valid,
  output logic       next,
  output logic       pipe_reset,
  output logic       playing,
  output logic [7:0] cell_count
);

  // Counter must reach (DWELL_BASE << 3) - 1 for the 8x setting.
  localparam int DW_W = $clog2(DWELL_BASE) + 3;
  localparam int RC_W = $clog2(RESTART_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LAST    = RC_W'(RESTART_CYCLES - 1);
  localparam logic [DW_W-1:0] DWELL_INIT = DW_W'(DWELL_BASE - 1);

  logic next_ev;
  logic play_ev;
  logic rst_ev;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_next_raw),
    .press (next_ev)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_play (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_play_raw),
    .press (play_ev)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_rst_raw),
    .press (rst_ev)
  );

  seq_state_t      state_q, state_d;
  logic            pending_q, pending_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic [DW_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DW_W-1:0] dwell_last_q, dwell_last_d;
  logic            next_d;
  logic            pipe_reset_d;
  logic            playing_d;
  logic [7:0]      cell_count_d;

  logic            can_pulse;
  logic            at_term;
  logic            dwell_clr;
  logic            dwell_inc;
  logic [DW_W-1:0] dwell_last_sel;

  assign dwell_last_sel = DW_W'(dwell_period(DWELL_BASE, dwell_sel) - 1);
  assign at_term        = (dwell_cnt_q == dwell_last_q);
  // The registered `next` doubles as the one-cycle hold-off between pulses.
  assign can_pulse      = braille_valid & ~next;

  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    rcnt_d       = rcnt_q;
    next_d       = 1'b0;
    pipe_reset_d = 1'b0;
    cell_count_d = cell_count;
    dwell_clr    = 1'b0;
    dwell_inc    = 1'b0;

    if (rst_ev && state_q != RESTART) begin
      state_d      = RESTART;
      pipe_reset_d = 1'b1;
      pending_d    = 1'b0;
      rcnt_d       = '0;
      cell_count_d = '0;
      dwell_clr    = 1'b1;
    end else begin
      case (state_q)
        PAUSED: begin
          dwell_clr = 1'b1;
          if (play_ev) begin
            state_d = PLAY;
          end else if (next_ev || pending_q) begin
            if (can_pulse) begin
              next_d    = 1'b1;
              pending_d = 1'b0;
            end else begin
              pending_d = 1'b1;
            end
          end
        end

        PLAY: begin
          if (play_ev) begin
            state_d   = PAUSED;
            pending_d = 1'b0;
            dwell_clr = 1'b1;
          end else if (next_ev || (pending_q && can_pulse)) begin
            dwell_clr = 1'b1;
            if (can_pulse) begin
              next_d    = 1'b1;
              pending_d = 1'b0;
            end else begin
              pending_d = 1'b1;
            end
          end else if (at_term) begin
            // Hold at the terminal count until the converter has a valid cell.
            if (can_pulse) begin
              next_d    = 1'b1;
              dwell_clr = 1'b1;
            end
          end else begin
            dwell_inc = 1'b1;
          end
        end

        RESTART: begin
          dwell_clr = 1'b1;
          pending_d = 1'b0;
          if (rcnt_q == RC_LAST) begin
            state_d = PAUSED;
          end else begin
            rcnt_d       = rcnt_q + 1'b1;
            pipe_reset_d = 1'b1;
          end
        end

        default: begin
          state_d   = PAUSED;
          pending_d = 1'b0;
          dwell_clr = 1'b1;
        end
      endcase
    end

    if (next_d && cell_count != CELL_COUNT_MAX) begin
      cell_count_d = cell_count + 8'd1;
    end

    playing_d = (state_d == PLAY);

    // The period limit is re-sampled on every clear, so dwell_sel changes land next period.
    if (dwell_clr) begin
      dwell_cnt_d  = '0;
      dwell_last_d = dwell_last_sel;
    end else begin
      dwell_cnt_d  = dwell_inc ? dwell_cnt_q + 1'b1 : dwell_cnt_q;
      dwell_last_d = dwell_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PAUSED;
      pending_q    <= 1'b0;
      rcnt_q       <= '0;
      dwell_cnt_q  <= '0;
      dwell_last_q <= DWELL_INIT;
      next         <= 1'b0;
      pipe_reset   <= 1'b0;
      playing      <= 1'b0;
      cell_count   <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      rcnt_q       <= rcnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      dwell_last_q <= dwell_last_d;
      next         <= next_d;
      pipe_reset   <= pipe_reset_d;
      playing      <= playing_d;
      cell_count   <= cell_count_d;
    end
  end

endmodule

// File: tb/tb_braille_playback_sequencer.sv
// Directed bench for braille_playback_sequencer with DEBOUNCE_CYCLES=4, DWELL_BASE=8, RESTART_CYCLES=4.
module tb_braille_playback_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_next_raw;
  logic       btn_play_raw;
  logic       btn_rst_raw;
  logic [1:0] dwell_sel;
  logic       braille_valid;
  logic       next;
  logic       pipe_reset;
  logic       playing;
  logic [7:0] cell_count;

  int errors = 0;
  int checks = 0;

  // Pulse monitor state, updated shortly after each rising edge.
  int   cyc            = 0;
  int   pulse_cnt      = 0;
  int   last_pulse_cyc = 0;
  int   gap            = 0;
  int   b2b            = 0;
  int   next_in_rst    = 0;
  logic prev_next      = 1'b0;

  int t0;
  int pc;

  braille_playback_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .DWELL_BASE      (8),
    .RESTART_CYCLES  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_next_raw  (btn_next_raw),
    .btn_play_raw  (btn_play_raw),
    .btn_rst_raw   (btn_rst_raw),
    .dwell_sel     (dwell_sel),
    .braille_valid (braille_valid),
    .next          (next),
    .pipe_reset    (pipe_reset),
    .playing       (playing),
    .cell_count    (cell_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    cyc       <= cyc + 1;
    prev_next <= next;
    if (next === 1'b1) begin
      pulse_cnt      <= pulse_cnt + 1;
      gap            <= cyc + 1 - last_pulse_cyc;
      last_pulse_cyc <= cyc + 1;
      if (prev_next === 1'b1) b2b <= b2b + 1;
      if (pipe_reset === 1'b1) next_in_rst <= next_in_rst + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // which: 0=next, 1=play, 2=restart. Holds the raw level high then low for `hold` cycles each.
  task automatic press(input int which, input int hold);
    case (which)
      0:       btn_next_raw = 1'b1;
      1:       btn_play_raw = 1'b1;
      default: btn_rst_raw  = 1'b1;
    endcase
    repeat (hold) tick();
    btn_next_raw = 1'b0;
    btn_play_raw = 1'b0;
    btn_rst_raw  = 1'b0;
    repeat (hold) tick();
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    int start;
    int n;
    start = pulse_cnt;
    n = 0;
    while (pulse_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(pulse_cnt != start), 32'd1);
  endtask

  initial begin
    reset         = 1'b1;
    btn_next_raw  = 1'b0;
    btn_play_raw  = 1'b0;
    btn_rst_raw   = 1'b0;
    dwell_sel     = 2'd0;
    braille_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_next",       32'(next),       32'd0);
    check("rst_pipe_reset", 32'(pipe_reset), 32'd0);
    check("rst_playing",    32'(playing),    32'd0);
    check("rst_cell_count", 32'(cell_count), 32'd0);

    // Manual press: pulse 8 cycles after the raw edge.
    braille_valid = 1'b1;
    t0 = cyc;
    pc = pulse_cnt;
    btn_next_raw = 1'b1;
    repeat (10) tick();
    btn_next_raw = 1'b0;
    check("t1_one_pulse",  32'(pulse_cnt - pc),      32'd1);
    check("t1_latency",    32'(last_pulse_cyc - t0), 32'd8);
    check("t1_cell_count", 32'(cell_count),          32'd1);
    repeat (10) tick();

    // A 2-cycle glitch never survives the debounce window.
    pc = pulse_cnt;
    btn_next_raw = 1'b1;
    repeat (2) tick();
    btn_next_raw = 1'b0;
    repeat (15) tick();
    check("t1_glitch_pulses", 32'(pulse_cnt - pc), 32'd0);
    check("t1_glitch_count",  32'(cell_count),     32'd1);

    // Play mode: 8-cycle period, then 64 after a mid-period dwell_sel change.
    press(1, 8);
    check("t2_playing", 32'(playing), 32'd1);
    wait_pulse("t2_sync_pulse", 40);
    wait_pulse("t2_pulse_a", 20);
    check("t2_gap_1x", 32'(gap), 32'd8);
    dwell_sel = 2'd3;
    wait_pulse("t2_pulse_b", 20);
    check("t2_gap_current_period", 32'(gap), 32'd8);
    wait_pulse("t2_pulse_c", 100);
    check("t2_gap_8x", 32'(gap), 32'd64);
    dwell_sel = 2'd0;
    wait_pulse("t2_pulse_d", 100);
    check("t2_gap_8x_latched", 32'(gap), 32'd64);
    wait_pulse("t2_pulse_e", 20);
    check("t2_gap_back_1x", 32'(gap), 32'd8);

    // Terminal count reached with valid low: hold, then pulse the cycle after valid returns.
    repeat (6) tick();
    braille_valid = 1'b0;
    pc = pulse_cnt;
    repeat (5) tick();
    check("t3_held_pulses", 32'(pulse_cnt - pc), 32'd0);
    check("t3_held_next",   32'(next),           32'd0);
    braille_valid = 1'b1;
    tick();
    check("t3_pulse_on_valid", 32'(next),    32'd1);
    check("t3_still_playing",  32'(playing), 32'd1);

    // Restart and play pressed together while playing: restart wins.
    btn_rst_raw  = 1'b1;
    btn_play_raw = 1'b1;
    repeat (7) tick();
    check("t5_pipe_reset_before", 32'(pipe_reset), 32'd0);
    tick();
    btn_rst_raw  = 1'b0;
    btn_play_raw = 1'b0;
    pc = pulse_cnt;
    check("t5_pipe_reset_first", 32'(pipe_reset), 32'd1);
    check("t5_playing_low",      32'(playing),    32'd0);
    check("t5_cell_count_clr",   32'(cell_count), 32'd0);
    repeat (3) tick();
    check("t5_pipe_reset_last", 32'(pipe_reset), 32'd1);
    tick();
    check("t5_pipe_reset_drop",   32'(pipe_reset),     32'd0);
    check("t5_no_next_in_restart", 32'(pulse_cnt - pc), 32'd0);
    repeat (10) tick();
    check("t5_paused_after", 32'(playing),    32'd0);
    check("t5_count_after",  32'(cell_count), 32'd0);

    // Paused with valid low: two presses collapse into one pending advance.
    braille_valid = 1'b0;
    pc = pulse_cnt;
    press(0, 8);
    press(0, 8);
    check("t4_no_pulse_invalid", 32'(pulse_cnt - pc), 32'd0);
    check("t4_count_invalid",    32'(cell_count),     32'd0);
    braille_valid = 1'b1;
    tick();
    check("t4_pending_pulse", 32'(next),       32'd1);
    check("t4_count_one",     32'(cell_count), 32'd1);
    repeat (10) tick();
    check("t4_single_pulse", 32'(pulse_cnt - pc), 32'd1);
    check("t4_count_final",  32'(cell_count),     32'd1);

    // Saturation of cell_count at 255.
    for (int i = 0; i < 253; i++) press(0, 8);
    check("t6_count_254", 32'(cell_count), 32'd254);
    press(0, 8);
    check("t6_count_255", 32'(cell_count), 32'd255);
    pc = pulse_cnt;
    press(0, 8);
    check("t6_pulse_at_sat", 32'(pulse_cnt - pc), 32'd1);
    check("t6_count_holds",  32'(cell_count),     32'd255);

    // External reset in the middle of a restart.
    btn_rst_raw = 1'b1;
    repeat (9) tick();
    check("t6_mid_restart", 32'(pipe_reset), 32'd1);
    reset       = 1'b1;
    btn_rst_raw = 1'b0;
    tick();
    check("t6_reset_pipe_reset", 32'(pipe_reset), 32'd0);
    check("t6_reset_playing",    32'(playing),    32'd0);
    check("t6_reset_count",      32'(cell_count), 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    check("no_back_to_back_next",   32'(b2b),         32'd0);
    check("no_next_with_pipe_reset", 32'(next_in_rst), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
